uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an internal byte FIFO, configurable frame format and optional CTS flow control. Successor to the fixed 8N1, single-byte uart_tx used by the SoC and benches. It accepts words on a valid/ready stream, buffers them, and serialises them LSB-first on txd. It sits between the core's UART peripheral register interface, or a bench command driver, and the board TX pin.

---
 rtl/uart_tx_fifo.sv | 267 ++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
// Words arrive on a valid/ready stream and wait in a byte FIFO.
// They leave LSB-first on txd with a configurable frame format:
// start bit, DATA_BITS data bits, optional parity bit, then STOP_BITS stop bits.
// Optional feature macro UART_TX_CTS_EN adds the cts_n flow-control input.
// The input is double-flop synchronised, and a new frame is only started while it is low.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        tdata,
    input  logic                        tvld,
    output logic                        trdy,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
`ifdef UART_TX_CTS_EN
    ,
    input  logic                        cts_n
`endif
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int CW  = $clog2(DIV);

    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [CW-1:0]        baud_cnt_r, baud_nxt_s;
    logic [3:0]           bit_cnt_r, bit_nxt_s;
    logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
    logic                 par_r, par_nxt_s;
    logic                 txd_r, txd_nxt_s;
    logic                 trdy_r, busy_r;
    logic [LW-1:0]        level_r, level_nxt_s;
    logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic                 push_s, pop_s, tick_s, fifo_ne_s, cts_ok_s;
    logic [DATA_BITS-1:0] head_s;

    // Parity bit sent after the data: XOR of the data bits, inverted for odd parity.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
        logic p;
        p = ^word;
        if (PARITY == 1) begin
            parity_bit = ~p;
        end else begin
            parity_bit = p;
        end
    endfunction

    assign push_s    = tvld & trdy_r;
    assign fifo_ne_s = (level_r != {LW{1'b0}});
    assign head_s    = mem_r[rd_ptr_r];
    assign tick_s    = (baud_cnt_r == BAUD_LAST);

`ifdef UART_TX_CTS_EN
    logic cts_meta_r, cts_sync_r;

    // Two-flop synchroniser for the asynchronous clear-to-send input; resets to "not clear".
    always_ff @(posedge clk) begin
        if (rst) begin
            cts_meta_r <= 1'b1;
            cts_sync_r <= 1'b1;
        end else begin
            cts_meta_r <= cts_n;
            cts_sync_r <= cts_meta_r;
        end
    end

    assign cts_ok_s = ~cts_sync_r;
`else
    assign cts_ok_s = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic, plus the pop decision and the shifter/parity loads that go with it.
    always_comb begin
        state_nxt_s = state_r;
        bit_nxt_s   = bit_cnt_r;
        shift_nxt_s = shift_r;
        par_nxt_s   = par_r;
        pop_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (fifo_ne_s && cts_ok_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = S_START;
                    shift_nxt_s = head_s;
                    par_nxt_s   = parity_bit(head_s);
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s) begin
                    state_nxt_s = S_DATA;
                    bit_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = S_START;
                end
            end
            S_DATA: begin
                if (tick_s && (bit_cnt_r == DATA_LAST)) begin
                    bit_nxt_s = 4'd0;
                    if (PARITY != 0) begin
                        state_nxt_s = S_PAR;
                    end else begin
                        state_nxt_s = S_STOP;
                    end
                end else if (tick_s) begin
                    shift_nxt_s = {1'b0, shift_r[DATA_BITS-1:1]};
                    bit_nxt_s   = bit_cnt_r + 4'd1;
                end else begin
                    state_nxt_s = S_DATA;
                end
            end
            S_PAR: begin
                if (tick_s) begin
                    state_nxt_s = S_STOP;
                    bit_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = S_PAR;
                end
            end
            S_STOP: begin
                if (tick_s && (bit_cnt_r == STOP_LAST)) begin
                    // Back-to-back pop keeps consecutive frames free of idle gaps.
                    if (fifo_ne_s && cts_ok_s) begin
                        pop_s       = 1'b1;
                        state_nxt_s = S_START;
                        shift_nxt_s = head_s;
                        par_nxt_s   = parity_bit(head_s);
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end else if (tick_s) begin
                    bit_nxt_s = bit_cnt_r + 4'd1;
                end else begin
                    state_nxt_s = S_STOP;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Output decode: line level for the state being entered, so txd is registered with no lag.
    always_comb begin
        txd_nxt_s = 1'b1;
        case (state_nxt_s)
            S_IDLE:  txd_nxt_s = 1'b1;
            S_START: txd_nxt_s = 1'b0;
            S_DATA:  txd_nxt_s = shift_nxt_s[0];
            S_PAR:   txd_nxt_s = par_nxt_s;
            S_STOP:  txd_nxt_s = 1'b1;
            default: txd_nxt_s = 1'b1;
        endcase
    end

    // Baud counter: restarts on every state entry and on each bit wrap, and holds at zero while idle.
    always_comb begin
        if ((state_nxt_s == S_IDLE) || (state_nxt_s != state_r) || tick_s) begin
            baud_nxt_s = {CW{1'b0}};
        end else begin
            baud_nxt_s = baud_cnt_r + BAUD_ONE;
        end
    end

    // Occupancy bookkeeping: a simultaneous push and pop leaves the level unchanged.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Serialiser datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt_r <= {CW{1'b0}};
            bit_cnt_r  <= 4'd0;
            shift_r    <= {DATA_BITS{1'b0}};
            par_r      <= 1'b0;
        end else begin
            baud_cnt_r <= baud_nxt_s;
            bit_cnt_r  <= bit_nxt_s;
            shift_r    <= shift_nxt_s;
            par_r      <= par_nxt_s;
        end
    end

    // FIFO pointers and level; reset discards any buffered words.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_nxt_s;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= tdata;
        end
    end

    // Registered outputs, computed from next-cycle values so they align with state and level.
    always_ff @(posedge clk) begin
        if (rst) begin
            txd_r  <= 1'b1;
            trdy_r <= 1'b1;
            busy_r <= 1'b0;
        end else begin
            txd_r  <= txd_nxt_s;
            trdy_r <= (level_nxt_s != LVL_FULL);
            busy_r <= (state_nxt_s != S_IDLE) || (level_nxt_s != {LW{1'b0}});
        end
    end

    assign txd   = txd_r;
    assign trdy  = trdy_r;
    assign busy  = busy_r;
    assign level = level_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo.
// Instance u_a runs the default configuration (DIV = 434).
// Instance u_b is 8N1 at DIV = 4, with a line decoder on its output.
// Instance u_c is 7E2 at DIV = 4 and instance u_d is 7O2 at DIV = 4.
// Define UART_TX_CTS_EN to also exercise the clear-to-send hold-off on u_b.
module tb_uart_tx_fifo;

    logic       tb_clk = 1'b0;
    logic       rst;
    logic [7:0] tdata_a, tdata_b;
    logic [6:0] tdata_c, tdata_d;
    logic       tvld_a, tvld_b, tvld_c, tvld_d;
    logic       trdy_a, trdy_b, trdy_c, trdy_d;
    logic       txd_a, txd_b, txd_c, txd_d;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic [4:0] level_a, level_b, level_c, level_d;
    logic       cts_lo = 1'b0;
    logic       cts_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 tb_clk = ~tb_clk;

    uart_tx_fifo u_a (
        .clk(tb_clk), .rst(rst), .tdata(tdata_a), .tvld(tvld_a), .trdy(trdy_a),
        .txd(txd_a), .busy(busy_a), .level(level_a)
`ifdef UART_TX_CTS_EN
        , .cts_n(cts_lo)
`endif
    );

    uart_tx_fifo #(.CLK_FREQ(400), .BAUD_RATE(100)) u_b (
        .clk(tb_clk), .rst(rst), .tdata(tdata_b), .tvld(tvld_b), .trdy(trdy_b),
        .txd(txd_b), .busy(busy_b), .level(level_b)
`ifdef UART_TX_CTS_EN
        , .cts_n(cts_b)
`endif
    );

    uart_tx_fifo #(.CLK_FREQ(400), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_c (
        .clk(tb_clk), .rst(rst), .tdata(tdata_c), .tvld(tvld_c), .trdy(trdy_c),
        .txd(txd_c), .busy(busy_c), .level(level_c)
`ifdef UART_TX_CTS_EN
        , .cts_n(cts_lo)
`endif
    );

    uart_tx_fifo #(.CLK_FREQ(400), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_d (
        .clk(tb_clk), .rst(rst), .tdata(tdata_d), .tvld(tvld_d), .trdy(trdy_d),
        .txd(txd_d), .busy(busy_d), .level(level_d)
`ifdef UART_TX_CTS_EN
        , .cts_n(cts_lo)
`endif
    );

    // Line decoder for u_b: samples mid-bit (DIV = 4) and collects the received bytes.
    logic [7:0] rx_q[$];
    int         dec_cnt = -1;
    logic [7:0] dec_sh  = 8'h00;
    always @(negedge tb_clk) begin
        if (rst) begin
            dec_cnt <= -1;
        end else if (dec_cnt < 0) begin
            if (txd_b == 1'b0) dec_cnt <= 1;
        end else begin
            if (dec_cnt == 38) begin
                rx_q.push_back(dec_sh);
                dec_cnt <= -1;
            end else begin
                dec_cnt <= dec_cnt + 1;
            end
            if (dec_cnt >= 6 && dec_cnt <= 34 && (dec_cnt % 4) == 2)
                dec_sh <= {txd_b, dec_sh[7:1]};
        end
    end

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_q.size()) return 32'(rx_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        logic [7:0]  b55;
        logic [10:0] exp_c, exp_d;
        int w;
        int tmo;

        b55   = 8'h55;
        exp_c = {2'b11, 1'b1, 7'b0000111, 1'b0};
        exp_d = {2'b11, 1'b0, 7'b0000111, 1'b0};
        rst = 1'b1;
        tdata_a = 8'h00; tdata_b = 8'h00; tdata_c = 7'h00; tdata_d = 7'h00;
        tvld_a = 1'b0; tvld_b = 1'b0; tvld_c = 1'b0; tvld_d = 1'b0;
        cts_b = 1'b0;
        ticks(3);

        // Reset state
        chk("rst_txd",   32'(txd_a),   32'd1);
        chk("rst_trdy",  32'(trdy_a),  32'd1);
        chk("rst_busy",  32'(busy_a),  32'd0);
        chk("rst_level", 32'(level_a), 32'd0);
        chk("rst_txd_b", 32'(txd_b),   32'd1);
        rst = 1'b0;
        ticks(5);

        // Single 0x55 frame at DIV = 434
        tdata_a = 8'h55; tvld_a = 1'b1;
        tick();
        tvld_a = 1'b0;
        chk("t1_push_txd",   32'(txd_a),   32'd1);
        chk("t1_push_level", 32'(level_a), 32'd1);
        chk("t1_push_busy",  32'(busy_a),  32'd1);
        tick();
        chk("t1_start_edge", 32'(txd_a),   32'd0);
        chk("t1_pop_level",  32'(level_a), 32'd0);
        ticks(217);
        chk("t1_start_mid", 32'(txd_a), 32'd0);
        for (int j = 0; j < 8; j++) begin
            ticks(434);
            chk($sformatf("t1_bit%0d", j), 32'(txd_a), 32'(b55[j]));
        end
        ticks(434);
        chk("t1_stop", 32'(txd_a), 32'd1);
        ticks(216);
        chk("t1_busy_last", 32'(busy_a), 32'd1);
        tick();
        chk("t1_busy_drop", 32'(busy_a), 32'd0);
        chk("t1_idle_txd",  32'(txd_a),  32'd1);

        // Reset 1000 cycles into a frame with five words queued
        for (int i = 0; i < 6; i++) begin
            tdata_a = 8'hA0 + 8'(i); tvld_a = 1'b1;
            tick();
        end
        tvld_a = 1'b0;
        ticks(996);
        chk("rr_level_before", 32'(level_a), 32'd5);
        chk("rr_busy_before",  32'(busy_a),  32'd1);
        rst = 1'b1;
        tick();
        chk("rr_txd",   32'(txd_a),   32'd1);
        chk("rr_level", 32'(level_a), 32'd0);
        chk("rr_busy",  32'(busy_a),  32'd0);
        chk("rr_trdy",  32'(trdy_a),  32'd1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ticks(100);
            chk($sformatf("rr_quiet_txd%0d", i), 32'(txd_a), 32'd1);
            chk($sformatf("rr_quiet_busy%0d", i), 32'(busy_a), 32'd0);
        end

        // Fill the FIFO of u_b with 0x00..0x13, holding tvld until trdy
        tmo = 0;
        for (int i = 0; i < 20; i++) begin
            tdata_b = 8'(i); tvld_b = 1'b1;
            w = 0;
            while (!trdy_b && w < 500) begin
                tick();
                w++;
            end
            if (w >= 500) tmo++;
            tick();
            if (i == 16) begin
                chk("fill_level16", 32'(level_b), 32'd16);
                chk("fill_trdy_low", 32'(trdy_b), 32'd0);
            end
        end
        tvld_b = 1'b0;
        chk("fill_timeout", 32'(tmo), 32'd0);
        w = 0;
        while (busy_b && w < 3000) begin
            tick();
            w++;
        end
        chk("fill_drain", 32'(busy_b), 32'd0);
        ticks(4);
        chk("fill_rx_count", 32'(rx_q.size()), 32'd20);
        for (int i = 0; i < 20; i++)
            chk($sformatf("fill_rx%0d", i), rx_at(i), 32'(i));

        // Back-to-back frames 0xA5, 0x3C with no idle gap
        tdata_b = 8'hA5; tvld_b = 1'b1;
        tick();
        tdata_b = 8'h3C;
        tick();
        tvld_b = 1'b0;
        chk("bb_start1", 32'(txd_b), 32'd0);
        ticks(39);
        chk("bb_last_stop", 32'(txd_b), 32'd1);
        tick();
        chk("bb_start2", 32'(txd_b),  32'd0);
        chk("bb_busy",   32'(busy_b), 32'd1);
        w = 0;
        while (busy_b && w < 500) begin
            tick();
            w++;
        end
        chk("bb_drain", 32'(busy_b), 32'd0);
        ticks(4);
        chk("bb_rx0", rx_at(20), 32'h0000_00A5);
        chk("bb_rx1", rx_at(21), 32'h0000_003C);

        // Parity frames: 0x07 as 7E2 on u_c and as 7O2 on u_d
        tdata_c = 7'h07; tdata_d = 7'h07; tvld_c = 1'b1; tvld_d = 1'b1;
        tick();
        tvld_c = 1'b0; tvld_d = 1'b0;
        tick();
        ticks(2);
        for (int j = 0; j < 11; j++) begin
            chk($sformatf("par_even_b%0d", j), 32'(txd_c), 32'(exp_c[j]));
            chk($sformatf("par_odd_b%0d", j),  32'(txd_d), 32'(exp_d[j]));
            if (j < 10) ticks(4);
        end
        tick();
        chk("par_busy_last", 32'(busy_c), 32'd1);
        tick();
        chk("par_even_end", 32'(busy_c), 32'd0);
        chk("par_odd_end",  32'(busy_d), 32'd0);

`ifdef UART_TX_CTS_EN
        // Clear-to-send hold-off on u_b
        cts_b = 1'b1;
        ticks(3);
        tdata_b = 8'h41; tvld_b = 1'b1;
        tick();
        tdata_b = 8'h42;
        tick();
        tvld_b = 1'b0;
        ticks(10);
        chk("cts_hold_txd",   32'(txd_b),   32'd1);
        chk("cts_hold_busy",  32'(busy_b),  32'd1);
        chk("cts_hold_level", 32'(level_b), 32'd2);
        cts_b = 1'b0;
        ticks(2);
        chk("cts_sync_txd", 32'(txd_b), 32'd1);
        tick();
        chk("cts_start", 32'(txd_b), 32'd0);
        ticks(20);
        cts_b = 1'b1;
        ticks(20);
        chk("cts_frame_done", 32'(txd_b),   32'd1);
        chk("cts_level_held", 32'(level_b), 32'd1);
        ticks(40);
        chk("cts_still_held", 32'(txd_b),  32'd1);
        chk("cts_busy_held",  32'(busy_b), 32'd1);
        chk("cts_rx0",        rx_at(22),   32'h0000_0041);
        cts_b = 1'b0;
        w = 0;
        while (busy_b && w < 500) begin
            tick();
            w++;
        end
        chk("cts_drain", 32'(busy_b), 32'd0);
        ticks(4);
        chk("cts_rx1", rx_at(23), 32'h0000_0042);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
